pc_fetch: RTL and testbench

//   Program-counter and fetch-control stage directly upstream of the instruction ROM.

---
 rtl/pc_defs.sv | 15 +
 rtl/next_pc_calc.sv | 38 +++
 rtl/pc_fetch.sv | 95 +++++++++
 tb/tb_pc_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_defs.sv
// Shared encodings for the fetch stage: FSM state codes and next-PC select codes.
package pc_defs;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_HALT  = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection and target legality against the ROM window.
module next_pc_calc
  import pc_defs::*;
#(
  parameter int ROM_BYTES = 100
) (
  input  logic [31:0] pc,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] immExt,
  input  logic [25:0] jTarget,
  input  logic [31:0] rsData,
  output logic [31:0] next,
  output logic [31:0] pcPlus4,
  output logic        illegal
);

  localparam logic [31:0] MAX_ADDR = 32'(ROM_BYTES - 4);

  logic [31:0] br_offset;

  assign pcPlus4   = pc + 32'd4;
  assign br_offset = {immExt[29:0], 2'b00};

  always_comb begin
    next = pcPlus4;
    case (pcSrc)
      PC_SEQ:  next = pcPlus4;
      PC_BR:   next = pcPlus4 + br_offset;
      PC_J:    next = {pcPlus4[31:28], jTarget, 2'b00};
      PC_JR:   next = rsData;
      default: next = pcPlus4;
    endcase
  end

  // Unsigned compare: a backward branch that wraps below zero lands far above the ROM.
  assign illegal = (next[1:0] != 2'b00) || (next > MAX_ADDR);

endmodule

// File: rtl/pc_fetch.sv
// PC register and fetch-control FSM feeding the instruction ROM; halts or faults sticky until reset.
module pc_fetch
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 100
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        pcWre,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] immExt,
  input  logic [25:0] jTarget,
  input  logic [31:0] rsData,
  input  logic        haltReq,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        nrd,
  output logic [1:0]  state,
  output logic        fault,
  output logic [31:0] faultPc,
  output logic [31:0] instCnt
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] fault_pc_reg, fault_pc_next;
  logic [31:0] inst_cnt_reg, inst_cnt_next;
  logic [31:0] target;
  logic        target_illegal;

  next_pc_calc #(
    .ROM_BYTES(ROM_BYTES)
  ) u_next_pc_calc (
    .pc      (pc_reg),
    .pcSrc   (pcSrc),
    .immExt  (immExt),
    .jTarget (jTarget),
    .rsData  (rsData),
    .next    (target),
    .pcPlus4 (pcPlus4),
    .illegal (target_illegal)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= S_RUN;
      pc_reg       <= RESET_PC;
      fault_pc_reg <= 32'd0;
      inst_cnt_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      fault_pc_reg <= fault_pc_next;
      inst_cnt_reg <= inst_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fault_pc_next = fault_pc_reg;
    inst_cnt_next = inst_cnt_reg;
    case (state_reg)
      S_RUN: begin
        if (haltReq) begin
          state_next = S_HALT;
        end else if (pcWre) begin
          if (target_illegal) begin
            state_next    = S_FAULT;
            fault_pc_next = target;
          end else begin
            pc_next = target;
            if (inst_cnt_reg != 32'hFFFF_FFFF)
              inst_cnt_next = inst_cnt_reg + 32'd1;
          end
        end
      end
      S_HALT, S_FAULT: ;
      // Corrupted state register: park in FAULT and record where we were.
      default: begin
        state_next    = S_FAULT;
        fault_pc_next = pc_reg;
      end
    endcase
  end

  assign pc      = pc_reg;
  assign state   = state_reg;
  assign nrd     = (state_reg != S_RUN);
  assign fault   = (state_reg == S_FAULT);
  assign faultPc = fault_pc_reg;
  assign instCnt = inst_cnt_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: reset, sequencing, branch/jump, stall, fault and halt behaviour.
module tb_pc_fetch;

  logic        clk;
  logic        nrst;
  logic        pcWre;
  logic [1:0]  pcSrc;
  logic [31:0] immExt;
  logic [25:0] jTarget;
  logic [31:0] rsData;
  logic        haltReq;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        nrd;
  logic [1:0]  state;
  logic        fault;
  logic [31:0] faultPc;
  logic [31:0] instCnt;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_BYTES(100)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .pcWre   (pcWre),
    .pcSrc   (pcSrc),
    .immExt  (immExt),
    .jTarget (jTarget),
    .rsData  (rsData),
    .haltReq (haltReq),
    .pc      (pc),
    .pcPlus4 (pcPlus4),
    .nrd     (nrd),
    .state   (state),
    .fault   (fault),
    .faultPc (faultPc),
    .instCnt (instCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance n rising edges, then sit 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between edges.
  task automatic pulse_reset();
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
  endtask

  task automatic set_in(input logic wre, input logic [1:0] src, input logic [31:0] imm,
                        input logic [25:0] jt, input logic [31:0] rs, input logic hlt);
    pcWre   = wre;
    pcSrc   = src;
    immExt  = imm;
    jTarget = jt;
    rsData  = rs;
    haltReq = hlt;
  endtask

  initial begin
    nrst = 1'b0;
    set_in(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
    step(2);
    check("cold_pc", pc, 32'h0);
    check("cold_state", 32'(state), 32'd0);
    check("cold_nrd", 32'(nrd), 32'd0);
    check("cold_fault", 32'(fault), 32'd0);
    check("cold_faultpc", faultPc, 32'h0);
    check("cold_cnt", instCnt, 32'd0);
    nrst = 1'b1;

    // Sequential run to 0x10, then async reset lands before the next edge.
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check($sformatf("seq_pc_%0d", i), pc, 32'(4 * i));
    end
    check("seq_plus4", pcPlus4, 32'h14);
    nrst = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_nrd", 32'(nrd), 32'd0);
    check("async_rst_cnt", instCnt, 32'd0);
    nrst = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      step(1);
      check($sformatf("run_pc_%0d", i), pc, 32'(4 * i));
    end
    check("run_cnt", instCnt, 32'd5);

    // Branch back one word from pc=8, then jump to 0x40.
    pulse_reset();
    step(2);
    check("pre_br_pc", pc, 32'h8);
    set_in(1'b1, 2'b01, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0);
    step(1);
    check("branch_pc", pc, 32'h4);
    set_in(1'b1, 2'b10, 32'd0, 26'h10, 32'd0, 1'b0);
    step(1);
    check("jump_pc", pc, 32'h40);
    check("jump_cnt", instCnt, 32'd4);

    // Stall at 0x0C with an illegal jr target present.
    pulse_reset();
    set_in(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
    step(3);
    check("pre_stall_pc", pc, 32'hC);
    set_in(1'b0, 2'b11, 32'd0, 26'd0, 32'd3, 1'b0);
    step(3);
    check("stall_pc", pc, 32'hC);
    check("stall_cnt", instCnt, 32'd3);
    check("stall_state", 32'(state), 32'd0);
    check("stall_fault", 32'(fault), 32'd0);

    // jr out of range from the stalled point.
    set_in(1'b1, 2'b11, 32'd0, 26'd0, 32'h62, 1'b0);
    step(1);
    check("f62_state", 32'(state), 32'd2);
    check("f62_fault", 32'(fault), 32'd1);
    check("f62_faultpc", faultPc, 32'h62);
    check("f62_pc", pc, 32'hC);
    check("f62_nrd", 32'(nrd), 32'd1);
    set_in(1'b1, 2'b11, 32'd0, 26'd0, 32'h10, 1'b0);
    step(2);
    check("f62_hold_pc", pc, 32'hC);
    check("f62_hold_state", 32'(state), 32'd2);
    check("f62_hold_cnt", instCnt, 32'd3);

    // jr to exactly ROM_BYTES is one word past the last legal address.
    pulse_reset();
    check("rst_from_fault_state", 32'(state), 32'd0);
    check("rst_from_fault_faultpc", faultPc, 32'h0);
    set_in(1'b1, 2'b11, 32'd0, 26'd0, 32'd100, 1'b0);
    step(1);
    check("f100_state", 32'(state), 32'd2);
    check("f100_faultpc", faultPc, 32'd100);

    // Highest legal address is accepted.
    pulse_reset();
    set_in(1'b1, 2'b11, 32'd0, 26'd0, 32'd96, 1'b0);
    step(1);
    check("jr96_pc", pc, 32'd96);
    check("jr96_state", 32'(state), 32'd0);

    // Misaligned but in-range target.
    pulse_reset();
    set_in(1'b1, 2'b11, 32'd0, 26'd0, 32'd6, 1'b0);
    step(1);
    check("mis_state", 32'(state), 32'd2);
    check("mis_faultpc", faultPc, 32'd6);

    // Backward branch wrapping below zero.
    pulse_reset();
    set_in(1'b1, 2'b01, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0);
    step(1);
    check("wrap_state", 32'(state), 32'd2);
    check("wrap_faultpc", faultPc, 32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'h0);

    // Halt beats a pending jump and holds until reset.
    pulse_reset();
    set_in(1'b1, 2'b10, 32'd0, 26'h8, 32'd0, 1'b0);
    step(1);
    check("pre_halt_pc", pc, 32'h20);
    set_in(1'b1, 2'b10, 32'd0, 26'h10, 32'd0, 1'b1);
    step(1);
    check("halt_state", 32'(state), 32'd1);
    check("halt_pc", pc, 32'h20);
    check("halt_nrd", 32'(nrd), 32'd1);
    check("halt_fault", 32'(fault), 32'd0);
    set_in(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, 1'b0);
    step(10);
    check("halt_hold_pc", pc, 32'h20);
    check("halt_hold_state", 32'(state), 32'd1);
    check("halt_hold_cnt", instCnt, 32'd1);
    pulse_reset();
    check("halt_rst_state", 32'(state), 32'd0);
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_nrd", 32'(nrd), 32'd0);
    step(1);
    check("post_halt_run_pc", pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
